// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply/divide sequencer owning the HI/LO registers.
// Latency: MTHI/MTLO 1 edge; MULT/DIV result written 33 edges after accept, done_o in the cycle after.
// Backpressure: busy_o high in CALC/FIX; start_i while busy is dropped, so the pipeline must hold it.
//
// Ports: clk_i, rst_i (sync, active-high), start_i/op_i/src0_i/src1_i request,
//        cancel_i flush, busy_o/done_o/div0_o status, hi_o/lo_o architectural HI/LO.
// Optional macro MULDIV_FAST_MUL_EN: MULT/MULTU bypass CALC through a single-cycle
// multiplier in FIX (done_o 2 cycles after accept). Division is unaffected.
module muldiv_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] src0_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic             cancel_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div0_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [1:0]         state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic [WIDTH-1:0]   opnd;      // multiplicand (MUL) or divisor (DIV), absolute value
   logic [2*WIDTH-1:0] acc;       // MUL {partial, multiplier}; DIV {rem, quo/dividend}
   logic               is_div, neg_res, neg_rem, div0_q;

   // Request decode for the accepting edge
   logic               op_sgn, op_div, s0, s1, op_mul;
   logic [WIDTH-1:0]   abs0, abs1;

   assign op_sgn = (op_i == OP_MULT) || (op_i == OP_DIV);
   assign op_div = (op_i == OP_DIV)  || (op_i == OP_DIVU);
   assign op_mul = (op_i == OP_MULT) || (op_i == OP_MULTU);
   assign s0     = op_sgn & src0_i[WIDTH-1];
   assign s1     = op_sgn & src1_i[WIDTH-1];
   assign abs0   = s0 ? (~src0_i + 1'b1) : src0_i;
   assign abs1   = s1 ? (~src1_i + 1'b1) : src1_i;

   // One iteration of the engine
   logic [WIDTH:0]     mul_sum, rem_sh, trial;
   logic [2*WIDTH-1:0] calc_next;

   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
   // Remainder shifted left with the next dividend bit brought in; it stays below
   // 2*divisor, so WIDTH+1 bits hold it and the borrow bit decides the quotient bit.
   assign rem_sh  = acc[2*WIDTH-1:WIDTH-1];
   assign trial   = rem_sh - {1'b0, opnd};
   assign calc_next = is_div
      ? {(trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0]), acc[WIDTH-2:0], ~trial[WIDTH]}
      : {mul_sum, acc[WIDTH-1:1]};

   // Sign fix-up applied at the FIX edge
   logic [2*WIDTH-1:0] mul_raw, prod;
   logic [WIDTH-1:0]   quo, rem;

`ifdef MULDIV_FAST_MUL_EN
   // Multiplies never pass through CALC here, so acc still holds {0, multiplier}.
   assign mul_raw = is_div ? acc
                           : ({{WIDTH{1'b0}}, acc[WIDTH-1:0]} * {{WIDTH{1'b0}}, opnd});
`else
   assign mul_raw = acc;
`endif
   assign prod = neg_res ? (~mul_raw + 1'b1) : mul_raw;
   assign quo  = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
   assign rem  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= S_IDLE;
         cnt     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         opnd    <= '0;
         acc     <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         div0_q  <= 1'b0;
      end else if (cancel_i) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               state <= S_IDLE;
               if (start_i) begin
                  if (op_i == OP_MTHI) begin
                     hi_q <= src0_i;
                  end else if (op_i == OP_MTLO) begin
                     lo_q <= src0_i;
                  end else if (op_mul || op_div) begin
                     is_div  <= op_div;
                     neg_res <= s0 ^ s1;
                     neg_rem <= s0;
                     div0_q  <= op_div && (src1_i == '0);
                     cnt     <= '0;
                     if (op_div) begin
                        acc  <= {{WIDTH{1'b0}}, abs0};
                        opnd <= abs1;
                     end else begin
                        acc  <= {{WIDTH{1'b0}}, abs1};
                        opnd <= abs0;
                     end
`ifdef MULDIV_FAST_MUL_EN
                     state <= (op_mul || (src1_i == '0)) ? S_FIX : S_CALC;
`else
                     state <= (op_div && (src1_i == '0)) ? S_FIX : S_CALC;
`endif
                  end
               end
            end
            S_CALC: begin
               acc <= calc_next;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) state <= S_FIX;
            end
            S_FIX: begin
               if (!div0_q) begin
                  if (is_div) begin
                     lo_q <= quo;
                     hi_q <= rem;
                  end else begin
                     {hi_q, lo_q} <= prod;
                  end
               end
               state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy_o = (state == S_CALC) || (state == S_FIX);
   assign done_o = (state == S_DONE);
   assign div0_o = (state == S_DONE) && div0_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: HI/LO moves, signed/unsigned mul/div, div-by-zero,
// cancel, reset mid-operation and back-to-back issue, with hand-computed results.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst_i, start_i, cancel_i;
   logic [2:0]  op_i;
   logic [31:0] src0_i, src1_i;
   logic        busy_o, done_o, div0_o;
   logic [31:0] hi_o, lo_o;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
      .src0_i(src0_i), .src1_i(src1_i), .cancel_i(cancel_i),
      .busy_o(busy_o), .done_o(done_o), .div0_o(div0_o),
      .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Counts edges until done_o, bounded so a stuck DUT still reaches the summary.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!done_o && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   // Issues one request; returns busy right after the accepting edge and the edge count to done_o.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic busy_after, output int lat);
      start_i = 1'b1; op_i = op; src0_i = a; src1_i = b;
      tick();
      start_i = 1'b0;
      busy_after = busy_o;
      wait_done(lat);
   endtask

   task automatic mov(input logic [2:0] op, input logic [31:0] a);
      start_i = 1'b1; op_i = op; src0_i = a; src1_i = '0;
      tick();
      start_i = 1'b0;
   endtask

   initial begin
      logic bsy;
      int   lat;
      int   dones;

      rst_i = 1'b1; start_i = 1'b0; cancel_i = 1'b0; op_i = '0; src0_i = '0; src1_i = '0;
      repeat (2) tick();
      chk("reset_hilo", {hi_o, lo_o}, 64'h0);
      chk("reset_flags", {61'h0, busy_o, done_o, div0_o}, 64'h0);
      rst_i = 1'b0;

      // MTHI then MTLO: single edge each, engine never busy, no done
      mov(3'd5, 32'h1234_5678);
      chk("mthi_hi", hi_o, 32'h1234_5678);
      chk("mthi_flags", {62'h0, busy_o, done_o}, 64'h0);
      mov(3'd6, 32'h9ABC_DEF0);
      chk("mtlo_hilo", {hi_o, lo_o}, 64'h1234_5678_9ABC_DEF0);
      chk("mtlo_flags", {62'h0, busy_o, done_o}, 64'h0);

      // MULT -1 * 2 = -2 (64-bit)
      do_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, bsy, lat);
      chk("mult_busy", {63'h0, bsy}, 64'h1);
      chk("mult_lat", 64'(lat), 64'(MUL_LAT));
      chk("mult_res", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("mult_done_busy", {62'h0, done_o, busy_o}, 64'h2);
      tick();
      chk("done_pulse", {63'h0, done_o}, 64'h0);

      // MULTU 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
      do_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, bsy, lat);
      chk("multu_res", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);

      // DIV -7 / 2 = -3 rem -1
      do_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, bsy, lat);
      chk("div_lat", 64'(lat), 64'(DIV_LAT));
      chk("div_res", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);

      // DIVU 100 / 7 = 14 rem 2
      do_op(3'd4, 32'd100, 32'd7, bsy, lat);
      chk("divu_res", {hi_o, lo_o}, {32'd2, 32'd14});

      // Signed overflow wraps: 0x80000000 / -1
      do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, bsy, lat);
      chk("div_ovf", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
      chk("div_ovf_div0", {63'h0, div0_o}, 64'h0);

      // Divide by zero: HI/LO untouched, done+div0 the cycle after the FIX edge
      mov(3'd5, 32'h0000_00AA);
      mov(3'd6, 32'h0000_00BB);
      do_op(3'd4, 32'd5, 32'd0, bsy, lat);
      chk("div0_lat", 64'(lat), 64'd1);
      chk("div0_flags", {62'h0, done_o, div0_o}, 64'h3);
      chk("div0_hilo", {hi_o, lo_o}, {32'hAA, 32'hBB});
      tick();
      chk("div0_pulse", {62'h0, done_o, div0_o}, 64'h0);

      // Cancel in the middle of a MULTU; a start while busy is dropped
      start_i = 1'b1; op_i = 3'd2; src0_i = 32'h1234; src1_i = 32'h5678;
      tick();
      start_i = 1'b0;
      repeat (10) tick();
      start_i = 1'b1; op_i = 3'd5; src0_i = 32'hDEAD_BEEF;
      tick();
      start_i = 1'b0;
      chk("busy_ignore_hi", hi_o, 32'hAA);
      chk("busy_still", {63'h0, busy_o}, 64'h1);
      cancel_i = 1'b1;
      tick();
      cancel_i = 1'b0;
      chk("cancel_busy", {62'h0, busy_o, done_o}, 64'h0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done_o) dones++;
      end
      chk("cancel_no_done", 64'(dones), 64'd0);
      chk("cancel_hilo", {hi_o, lo_o}, {32'hAA, 32'hBB});

      // Back-to-back: new DIVU accepted in the DONE cycle
      do_op(3'd4, 32'd100, 32'd7, bsy, lat);
      chk("b2b_first_done", {63'h0, done_o}, 64'h1);
      start_i = 1'b1; op_i = 3'd4; src0_i = 32'd9; src1_i = 32'd2;
      tick();
      start_i = 1'b0;
      chk("b2b_rebusy", {62'h0, busy_o, done_o}, 64'h2);
      wait_done(lat);
      chk("b2b_lat", 64'(lat), 64'(DIV_LAT));
      chk("b2b_res", {hi_o, lo_o}, {32'd1, 32'd4});

      // Reset in the middle of an operation
      start_i = 1'b1; op_i = 3'd3; src0_i = 32'd100; src1_i = 32'd7;
      tick();
      start_i = 1'b0;
      repeat (5) tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("midrst_hilo", {hi_o, lo_o}, 64'h0);
      chk("midrst_flags", {61'h0, busy_o, done_o, div0_o}, 64'h0);

      // MULTU 3 * 4 (fast path when enabled)
      do_op(3'd2, 32'd3, 32'd4, bsy, lat);
      chk("multu_small_lat", 64'(lat), 64'(MUL_LAT));
      chk("multu_small_res", {hi_o, lo_o}, 64'd12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and runs a radix-2 iterative engine, one bit per cycle.
- Raises busy_o so the pipeline stalls until the result is written.
- Takes the 64-bit mul/div work off the single-cycle ALU path.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH each.
- CNT_W, 5, iteration counter width; 2^CNT_W must equal WIDTH.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  request valid.
- op_i  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- src0_i  in  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO data).
- src1_i  in  WIDTH  rt operand (multiplier/divisor).
- cancel_i  in  1  pipeline flush; aborts an in-flight operation.
- busy_o  out  1  engine occupied; high in CALC and FIX.
- done_o  out  1  one-cycle pulse; HI/LO hold the new result.
- div0_o  out  1  one-cycle pulse together with done_o when the divisor is 0.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous and active-high.
- Reset values: state=IDLE; hi_o=0, lo_o=0; busy_o=0, done_o=0, div0_o=0; counter=0.
- States: IDLE, CALC, FIX, DONE.
- Accept rule: start_i is accepted on an edge when state is IDLE or DONE and cancel_i=0. A start_i while busy_o=1 is ignored, not queued; the pipeline must hold it.
- MTHI/MTLO: hi_o or lo_o ← src0_i on the accepting edge. State goes to IDLE, no done_o.
- NOP/reserved: no effect.
- MULT/MULTU/DIV/DIVU:
  - Accepting edge latches operands, op and sign flags into internal regs; signed ops take absolute values; counter=0; go to CALC.
- CALC (WIDTH cycles, counter 0..WIDTH-1):
  - MUL: shift-add; if the multiplier LSB is set, add the multiplicand to the upper accumulator half, then shift right 1.
  - DIV: restoring; shift {rem,quo} left 1; compute a WIDTH+1-bit trial subtract of the divisor; if no borrow, keep the difference and set quo LSB.
  - After counter=WIDTH-1, go to FIX.
- FIX (1 cycle), all in 2's complement:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
  - Write at the FIX edge: MUL {hi,lo}=product; DIV lo=quotient, hi=remainder.
  - Then go to DONE.
- DONE (1 cycle): done_o=1; busy_o=0. Next state is IDLE, or CALC if a new start is accepted.
- Latency: accepting edge E0 → CALC edges E1..E32 → FIX writes at E33 → done_o high in the cycle after E33. busy_o is high from after E0 until E33.
- Divide by zero: detected at accept. Skip CALC and go to FIX next edge. HI/LO are left unchanged; done_o=1 and div0_o=1 in DONE.
- Signed overflow (0x80000000 / 0xFFFFFFFF): natural wrap, lo=0x80000000, hi=0. No flag.
- cancel_i: on any edge with cancel_i=1, go to IDLE and drop the operation. HI/LO are not written and done_o stays 0. cancel_i has priority over accept and over the FIX write.
- Reset mid-operation: rst_i overrides everything and returns all registers to reset values next edge.
- MFHI/MFLO forwarding: hi_o/lo_o are register outputs. The pipeline must stall on busy_o before reading them.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU skip CALC. The accepting edge goes straight to FIX, which uses a combinational WIDTH×WIDTH multiplier on the latched abs operands plus the sign fix. done_o is high 2 cycles after the accepting edge. DIV is unchanged.
- Undefined: multiply uses the iterative path, 34-cycle latency.

Test Plan:
- Reset then MTHI 0x12345678, next cycle MTLO 0x9ABCDEF0 → hi_o=0x12345678, lo_o=0x9ABCDEF0; busy_o never high; no done_o.
- MULT 0xFFFFFFFF×0x00000002 → done_o one cycle after E33; hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2. Also DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 5/0 with hi=0xAA, lo=0xBB preset → done_o=1 and div0_o=1 two cycles after accept; hi/lo unchanged.
- MULTU started, cancel_i at iteration 10 → busy_o low next cycle, no done_o, hi/lo unchanged. A start_i pulsed while busy is ignored.
- Back-to-back: new DIVU accepted in the DONE cycle → busy_o re-asserts next cycle. With MULDIV_FAST_MUL_EN defined, MULTU 3×4 gives lo=12, hi=0, done_o 2 cycles after accept.
